// File: rtl/cap_regfile_pkg.sv
// Shared types and helpers for the capability register file.
// Build option: CAP_REGFILE_BYPASS_EN enables same-cycle write forwarding.
package cap_regfile_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } sweep_state_e;

  localparam bit RST_DATA_BIT = 1'b0;
  localparam bit RST_TAG      = 1'b0;

  function automatic int aw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cap_regfile_if.sv
// Write, read and sweep-control bundle of the capability register file.
// Build option: CAP_REGFILE_BYPASS_EN (affects read behaviour only).
interface cap_regfile_if #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NRPORTS = 2
);
  import cap_regfile_pkg::*;

  localparam int AW = aw_of(NREGS);

  logic                    we;
  logic [AW-1:0]           waddr;
  logic [XLEN-1:0]         wdata;
  logic                    wtag;
  logic [NRPORTS*AW-1:0]   raddr;
  logic [NRPORTS*XLEN-1:0] rdata;
  logic [NRPORTS-1:0]      rtag;
  logic                    sweep_req;
  logic                    sweep_busy;
  logic                    sweep_done;

  modport master (
    output we, waddr, wdata, wtag,
    output raddr, sweep_req,
    input  rdata, rtag,
    input  sweep_busy, sweep_done
  );

  modport slave (
    input  we, waddr, wdata, wtag,
    input  raddr, sweep_req,
    output rdata, rtag,
    output sweep_busy, sweep_done
  );

endinterface

// File: rtl/cap_regfile_sweep.sv
// Tag-sweep engine: walks entries 1..NREGS-1 issuing one tag clear per cycle.
// Build option: CAP_REGFILE_BYPASS_EN (no effect in this unit).
module cap_regfile_sweep
  import cap_regfile_pkg::*;
#(
  parameter int NREGS = 32,
  localparam int AW   = aw_of(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sweep_req,
  output logic          clr_en,
  output logic [AW-1:0] clr_idx,
  output logic          sweep_busy,
  output logic          sweep_done
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  sweep_state_e  state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Terminal compare on LAST; idx is never allowed to wrap.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (sweep_req) begin
          state_d = S_SWEEP;
          idx_d   = ONE;
        end
      end
      S_SWEEP: begin
        if (idx_q == LAST) state_d = S_DONE;
        else               idx_d   = idx_q + ONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    clr_en     = (state_q == S_SWEEP);
    clr_idx    = idx_q;
    sweep_busy = (state_q == S_SWEEP);
    sweep_done = (state_q == S_DONE);
  end

endmodule

// File: rtl/cap_regfile.sv
// Capability register file: XLEN data + tag per entry, entry 0 reads as zero.
// Build option: CAP_REGFILE_BYPASS_EN forwards same-cycle writes to reads.
module cap_regfile
  import cap_regfile_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NRPORTS = 2
) (
  input logic          clk,
  input logic          rst_n,
  cap_regfile_if.slave bus
);

  localparam int AW = aw_of(NREGS);

  logic [XLEN-1:0]         data_q [NREGS];
  logic [XLEN-1:0]         data_d [NREGS];
  logic [NREGS-1:0]        tag_q, tag_d;
  logic                    clr_en;
  logic [AW-1:0]           clr_idx;
  logic                    wr_hit;
  logic [NRPORTS*XLEN-1:0] rdata_w;
  logic [NRPORTS-1:0]      rtag_w;

  assign wr_hit = bus.we && (bus.waddr != '0);

  cap_regfile_sweep #(
    .NREGS(NREGS)
  ) u_sweep (
    .clk       (clk),
    .rst_n     (rst_n),
    .sweep_req (bus.sweep_req),
    .clr_en    (clr_en),
    .clr_idx   (clr_idx),
    .sweep_busy(bus.sweep_busy),
    .sweep_done(bus.sweep_done)
  );

  // Write is applied after the clear so it wins on a collision.
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    if (clr_en) tag_d[clr_idx] = RST_TAG;
    if (wr_hit) begin
      data_d[bus.waddr] = bus.wdata;
      tag_d[bus.waddr]  = bus.wtag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        data_q[i] <= {XLEN{RST_DATA_BIT}};
      tag_q <= {NREGS{RST_TAG}};
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

  for (genvar p = 0; p < NRPORTS; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            rt;

    assign ra = bus.raddr[p*AW +: AW];

    always_comb begin
      rd = data_q[ra];
      rt = tag_q[ra];
`ifdef CAP_REGFILE_BYPASS_EN
      if (wr_hit && (bus.waddr == ra)) begin
        rd = bus.wdata;
        rt = bus.wtag;
      end
`endif
      if (ra == '0) begin
        rd = '0;
        rt = 1'b0;
      end
    end

    assign rdata_w[p*XLEN +: XLEN] = rd;
    assign rtag_w[p]               = rt;
  end

  assign bus.rdata = rdata_w;
  assign bus.rtag  = rtag_w;

endmodule

// File: tb/tb_cap_regfile.sv
// Self-checking bench for cap_regfile: vector table, scoreboard and sweep sequences.
// Build option: CAP_REGFILE_BYPASS_EN selects the same-cycle read expectation.
module tb_cap_regfile;

  localparam int XLEN    = 32;
  localparam int NREGS   = 32;
  localparam int NRPORTS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cap_regfile_if #(
    .XLEN(XLEN), .NREGS(NREGS), .NRPORTS(NRPORTS)
  ) bus ();

  cap_regfile #(
    .XLEN(XLEN), .NREGS(NREGS), .NRPORTS(NRPORTS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        wt;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic        et0;
    logic [31:0] ed1;
    logic        et1;
  } vec_t;

  typedef struct {
    logic [31:0] d0;
    logic        t0;
    logic [31:0] d1;
    logic        t1;
  } exp_t;

  vec_t        vt [7];
  exp_t        sbq [$];
  int          nvec  = 0;
  int          nfail = 0;
  logic [31:0] m_d [NREGS];
  logic        m_t [NREGS];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic setra(input logic [4:0] a0, input logic [4:0] a1);
    bus.raddr = {a1, a0};
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d,
                    input logic t);
    @(negedge clk);
    bus.we    = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    bus.wtag  = t;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    if (a != 5'd0) begin
      m_d[a] = d;
      m_t[a] = t;
    end
  endtask

  task automatic rdchk(input string nm, input logic [4:0] a);
    setra(a, a);
    #1;
    chk({nm, " d0"}, bus.rdata[31:0], m_d[a]);
    chk({nm, " t0"}, {31'd0, bus.rtag[0]}, {31'd0, m_t[a]});
    chk({nm, " d1"}, bus.rdata[63:32], m_d[a]);
    chk({nm, " t1"}, {31'd0, bus.rtag[1]}, {31'd0, m_t[a]});
  endtask

  task automatic start_sweep();
    @(negedge clk);
    bus.sweep_req = 1'b1;
    @(posedge clk);
    #1;
    bus.sweep_req = 1'b0;
  endtask

  initial begin
    exp_t        e;
    int          nb, nd, done_at;
    logic [31:0] exp_same;

    for (int i = 0; i < NREGS; i++) begin
      m_d[i] = '0;
      m_t[i] = 1'b0;
    end
    bus.we        = 1'b0;
    bus.waddr     = '0;
    bus.wdata     = '0;
    bus.wtag      = 1'b0;
    bus.raddr     = '0;
    bus.sweep_req = 1'b0;

    vt[0] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,
              32'h0,        1'b0, 32'h0,        1'b0};
    vt[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd31, 5'd0,
              32'h0,        1'b0, 32'h0,        1'b0};
    vt[2] = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b1, 5'd3,  5'd3,
              32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1};
    vt[3] = '{1'b1, 5'd0,  32'h00001234, 1'b1, 5'd0,  5'd3,
              32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
    vt[4] = '{1'b1, 5'd31, 32'h0F0F0F0F, 1'b0, 5'd31, 5'd3,
              32'h0F0F0F0F, 1'b0, 32'hDEADBEEF, 1'b1};
    vt[5] = '{1'b1, 5'd5,  32'hFFFFFFFF, 1'b1, 5'd5,  5'd31,
              32'hFFFFFFFF, 1'b1, 32'h0F0F0F0F, 1'b0};
    vt[6] = '{1'b1, 5'd5,  32'h00000001, 1'b0, 5'd5,  5'd0,
              32'h00000001, 1'b0, 32'h0,        1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", {31'd0, bus.sweep_busy}, 32'd0);
    chk("rst done", {31'd0, bus.sweep_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors through the scoreboard
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.we    = vt[i].we;
      bus.waddr = vt[i].wa;
      bus.wdata = vt[i].wd;
      bus.wtag  = vt[i].wt;
      setra(vt[i].ra0, vt[i].ra1);
      sbq.push_back('{vt[i].ed0, vt[i].et0, vt[i].ed1, vt[i].et1});
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk($sformatf("vec%0d d0", i), bus.rdata[31:0], e.d0);
      chk($sformatf("vec%0d t0", i), {31'd0, bus.rtag[0]}, {31'd0, e.t0});
      chk($sformatf("vec%0d d1", i), bus.rdata[63:32], e.d1);
      chk($sformatf("vec%0d t1", i), {31'd0, bus.rtag[1]}, {31'd0, e.t1});
      bus.we = 1'b0;
      if (vt[i].we && vt[i].wa != 5'd0) begin
        m_d[vt[i].wa] = vt[i].wd;
        m_t[vt[i].wa] = vt[i].wt;
      end
    end

    // Same-cycle read of the entry being written
    @(negedge clk);
    bus.we    = 1'b1;
    bus.waddr = 5'd7;
    bus.wdata = 32'hA5A5A5A5;
    bus.wtag  = 1'b1;
    setra(5'd7, 5'd0);
    #1;
`ifdef CAP_REGFILE_BYPASS_EN
    exp_same = 32'hA5A5A5A5;
`else
    exp_same = m_d[7];
`endif
    chk("same-cycle x7", bus.rdata[31:0], exp_same);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    m_d[7] = 32'hA5A5A5A5;
    m_t[7] = 1'b1;
    chk("after-edge x7", bus.rdata[31:0], 32'hA5A5A5A5);

    // Full sweep
    for (int i = 1; i < NREGS; i++)
      wr(5'(i), (32'h01010101 * i) ^ 32'hC0DE0000, 1'b1);
    start_sweep();
    nb = 0;
    nd = 0;
    done_at = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.sweep_busy) nb++;
      if (bus.sweep_done) begin
        nd++;
        if (done_at < 0) done_at = c;
      end
    end
    chk("sweep busy cycles", nb, 32'd31);
    chk("sweep done cycles", nd, 32'd1);
    chk("sweep done slot", done_at, 32'd31);
    for (int i = 0; i < NREGS; i++) m_t[i] = 1'b0;
    for (int i = 0; i < NREGS; i++)
      rdchk($sformatf("swept x%0d", i), 5'(i));

    // Write collisions during a sweep
    @(negedge clk);
    bus.sweep_req = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      bus.sweep_req = 1'b0;
      bus.we        = 1'b0;
      if (k == 3 || k == 10 || k == 20) begin
        bus.we    = 1'b1;
        bus.waddr = (k == 3) ? 5'd20 : (k == 10) ? 5'd10 : 5'd5;
        bus.wdata = 32'h5000_0000 + k;
        bus.wtag  = 1'b1;
      end
    end
    bus.we = 1'b0;
    m_d[20] = 32'h5000_0003;
    m_t[20] = 1'b0;
    m_d[10] = 32'h5000_000A;
    m_t[10] = 1'b1;
    m_d[5]  = 32'h5000_0014;
    m_t[5]  = 1'b1;
    @(negedge clk);
    rdchk("coll x10", 5'd10);
    rdchk("coll x20", 5'd20);
    rdchk("coll x5", 5'd5);
    rdchk("coll x11", 5'd11);

    // Reset in the middle of a sweep
    wr(5'd12, 32'h12121212, 1'b1);
    start_sweep();
    repeat (11) @(posedge clk);
    #2;
    chk("mid idx busy", {31'd0, bus.sweep_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", {31'd0, bus.sweep_busy}, 32'd0);
    chk("midrst done", {31'd0, bus.sweep_done}, 32'd0);
    for (int i = 0; i < NREGS; i++) begin
      m_d[i] = '0;
      m_t[i] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++)
      rdchk($sformatf("midrst x%0d", i), 5'(i));

    // Restarted sweep begins again at entry 1
    wr(5'd1, 32'h11, 1'b1);
    wr(5'd2, 32'h22, 1'b1);
    start_sweep();
    @(posedge clk);
    #1;
    setra(5'd1, 5'd2);
    #1;
    chk("restart x1 tag", {31'd0, bus.rtag[0]}, 32'd0);
    chk("restart x2 tag", {31'd0, bus.rtag[1]}, 32'd1);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.sweep_done) nd++;
    end
    chk("restart done seen", nd, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/cap_regfile.md
# cap_regfile

Parametrised capability register file for the CHERI single-cycle core. Each entry holds an XLEN-bit value plus a validity tag. The block has NRPORTS combinational read ports and one synchronous write port, and entry 0 is hardwired to zero. A built-in tag-sweep engine clears every tag, one entry per cycle, on request, for context switch and revocation.

## Interface
Parameters:
- XLEN, 32, data width of each entry
- NREGS, 32, number of entries; power of two, at least 4
- NRPORTS, 2, number of read ports; 1 to 4

Derived: AW = log2(NREGS).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- we  in  1  write enable
- waddr  in  AW  write index
- wdata  in  XLEN  write value
- wtag  in  1  write tag
- raddr  in  NRPORTS*AW  packed read indices; port p uses bits [p*AW +: AW]
- rdata  out  NRPORTS*XLEN  packed read values
- rtag  out  NRPORTS  read tags, one per port
- sweep_req  in  1  start a tag sweep (level-sampled)
- sweep_busy  out  1  a sweep is in progress
- sweep_done  out  1  one-cycle pulse when a sweep completes

## Operation
- **Reads**
  - Purely combinational.
  - raddr slice of 0 gives rdata slice 0 and rtag bit 0.
  - Otherwise the port returns the stored value and tag.
- **Writes**
  - When we=1 and waddr≠0, the entry takes wdata and wtag at the clock edge.
  - Writes to entry 0 are discarded.
- **Sweep FSM states**: IDLE, SWEEP, DONE.
  - IDLE → SWEEP when sweep_req=1. The index counter loads 1.
  - SWEEP: at each edge, tag[idx] is cleared and idx increments. Data is untouched.
  - After clearing entry NREGS-1, the FSM moves SWEEP → DONE.
  - DONE → IDLE unconditionally.
  - sweep_req is ignored in SWEEP and DONE. A request held high through DONE starts a new sweep from IDLE on the following edge.
- **Outputs**: sweep_busy = (state==SWEEP); sweep_done = (state==DONE).
- **Write during sweep**
  - Writes are accepted normally.
  - If waddr equals the entry being cleared at that edge, the write wins: the tag becomes wtag.
  - A write to an already-swept entry keeps its written tag.
  - A write to a not-yet-swept entry is cleared when the sweep reaches it.
- **Reset**, asynchronous and valid at any time, including mid-sweep:
  - all data is 0 and all tags are 0
  - the FSM is in IDLE and idx is 0
  - sweep_busy=0, sweep_done=0

## Timing
- Read latency is 0 cycles. Write latency is 1 edge: the new value is visible on reads from the cycle after the edge.
- Sweep timeline, with sweep_req sampled at edge k:
  - sweep_busy is high from k+1 through k+NREGS-1.
  - Entry i is cleared at edge k+i.
  - sweep_done is high for the single cycle after edge k+NREGS-1.
  - The FSM returns to IDLE at edge k+NREGS.
  - Total sweep_busy duration is NREGS-1 cycles.
- Index arithmetic: idx is AW bits wide. The terminal compare is idx==NREGS-1 and idx never wraps. SWEEP→DONE uses that compare, not overflow.

## Configuration
- Macro: CAP_REGFILE_BYPASS_EN.
- **Defined**: a read port whose raddr equals waddr, with we=1 and waddr≠0, returns wdata and wtag in the same cycle (write-through forwarding).
  - A sweep clear is never forwarded.
- **Undefined**: reads always return the stored state (read-old). A same-cycle write becomes visible only after the edge.

## Structure
- **Package cap_regfile_pkg**
  - sweep state enum: IDLE, SWEEP, DONE
  - clog2-based AW helper function
  - reset constants: data 0, tag 0
- **Sub-module cap_regfile_sweep**
  - Contains the FSM and index counter.
  - Outputs: clr_en, clr_idx, sweep_busy, sweep_done.
  - The top level merges clr_en and clr_idx with the write port, write taking priority.

## Test plan
1. Reset then read: deassert rst_n, read entries 0, 5 and 31 → rdata=0 and rtag=0 on all ports.
2. Write then read: write x3=0xDEADBEEF with tag 1, then read x3 on both ports → 0xDEADBEEF, tag 1. Write x0=0x1234 → reads of x0 still return 0.
3. Same-cycle read and write: write x7=0xA5A5A5A5 while reading x7 →
   - with CAP_REGFILE_BYPASS_EN defined: returns 0xA5A5A5A5 in the same cycle
   - without it: returns the old value, then 0xA5A5A5A5 after the edge
4. Full sweep: set tags on x1–x31, pulse sweep_req →
   - sweep_busy high for exactly 31 cycles
   - sweep_done high for 1 cycle
   - all tags 0 and all data unchanged afterwards
5. Collision: during a sweep, write x10 with tag 1 on the edge that clears x10 → x10 tag is 1 after the sweep. Write x20 with tag 1 early in the sweep, before x20 is swept → x20 tag is 0 after the sweep.
6. Reset mid-sweep: assert rst_n low at sweep index 12 → the next cycle has sweep_busy=0 and all data and tags 0. The next sweep_req restarts from index 1.
